// File: rtl/region_dispatcher_if.sv
// Bundle of the dispatcher's request streams, region fan-out bus and status outputs.
// The master side is the upstream/region environment; the slave side is the dispatcher.
interface region_dispatcher_if #(
   parameter int HTTP_DATA_WIDTH   = 512,
   parameter int HTTP_META_WIDTH   = 98,
   parameter int OPERATOR_ID_WIDTH = 16,
   parameter int N_REGIONS         = 4
);
   logic                                     meta_tvalid;
   logic                                     meta_tready;
   logic [HTTP_META_WIDTH-1:0]               meta_tdata;

   logic                                     hdr_tvalid;
   logic                                     hdr_tready;
   logic                                     hdr_tlast;
   logic [HTTP_DATA_WIDTH-1:0]               hdr_tdata;

   logic                                     bdy_tvalid;
   logic                                     bdy_tready;
   logic                                     bdy_tlast;
   logic [HTTP_DATA_WIDTH-1:0]               bdy_tdata;

   logic [N_REGIONS*2*OPERATOR_ID_WIDTH-1:0] region_stats_in;

   logic [N_REGIONS-1:0]                     out_tvalid;
   logic [N_REGIONS-1:0]                     out_tready;
   logic [HTTP_DATA_WIDTH-1:0]               out_tdata;
   logic [1:0]                               out_tuser;
   logic                                     out_tlast;

   logic                                     pr_req;
   logic [31:0]                              pr_ctrl;
   logic [31:0]                              dispatch_cnt;

   modport master (
      output meta_tvalid, meta_tdata,
      output hdr_tvalid, hdr_tlast, hdr_tdata,
      output bdy_tvalid, bdy_tlast, bdy_tdata,
      output region_stats_in, out_tready,
      input  meta_tready, hdr_tready, bdy_tready,
      input  out_tvalid, out_tdata, out_tuser, out_tlast,
      input  pr_req, pr_ctrl, dispatch_cnt
   );

   modport slave (
      input  meta_tvalid, meta_tdata,
      input  hdr_tvalid, hdr_tlast, hdr_tdata,
      input  bdy_tvalid, bdy_tlast, bdy_tdata,
      input  region_stats_in, out_tready,
      output meta_tready, hdr_tready, bdy_tready,
      output out_tvalid, out_tdata, out_tuser, out_tlast,
      output pr_req, pr_ctrl, dispatch_cnt
   );
endinterface

// File: rtl/region_dispatcher.sv
// Routes one HTTP request (meta, headers, body) to the least-loaded region hosting its
// operator, requesting partial reconfiguration of the least-loaded region when none does.
module region_dispatcher #(
   parameter int HTTP_DATA_WIDTH      = 512,
   parameter int HTTP_META_WIDTH      = 98,
   parameter int HTTP_META_META_WIDTH = 48,
   parameter int HTTP_METHOD_WIDTH    = 32,
   parameter int OPERATOR_ID_WIDTH    = 16,
   parameter int N_REGIONS            = 4
) (
   input logic               aclk,
   input logic               areset,
   region_dispatcher_if.slave bus
);
   localparam int IDX_W   = $clog2(N_REGIONS);
   localparam int HDR_BIT = HTTP_META_META_WIDTH + HTTP_METHOD_WIDTH;
   localparam int BDY_BIT = HDR_BIT + 1;
   localparam int OID_LSB = HDR_BIT + 2;
   localparam int STATS_W = N_REGIONS * 2 * OPERATOR_ID_WIDTH;

   typedef enum logic [2:0] {
      IDLE,
      SELECT,
      SEND_META,
      SEND_HDR,
      SEND_BDY,
      DONE
   } state_t;

   state_t                       state_reg, state_next;
   logic [HTTP_META_WIDTH-1:0]   meta_reg;
   logic [IDX_W-1:0]             sel_reg, sel_next;
   logic [31:0]                  pr_ctrl_reg, pr_ctrl_next;
   logic [31:0]                  dispatch_cnt_reg;
   logic [STATS_W-1:0]           stats_reg;

   logic [OPERATOR_ID_WIDTH-1:0] region_oid [N_REGIONS];
   logic [OPERATOR_ID_WIDTH-1:0] region_cnt [N_REGIONS];

   logic [OPERATOR_ID_WIDTH-1:0] req_oid;
   logic                         has_hdr;
   logic                         has_bdy;

   logic                         match_found;
   logic [IDX_W-1:0]             match_idx;
   logic [OPERATOR_ID_WIDTH-1:0] match_cnt;
   logic [IDX_W-1:0]             any_idx;
   logic [OPERATOR_ID_WIDTH-1:0] any_cnt;

   logic                         load_meta;
   logic                         cnt_inc;
   logic                         meta_tready_c;
   logic                         hdr_tready_c;
   logic                         bdy_tready_c;
   logic                         valid_c;
   logic [HTTP_DATA_WIDTH-1:0]   tdata_c;
   logic [1:0]                   tuser_c;
   logic                         tlast_c;
   logic                         pr_req_c;
   logic                         ready_sel;

   assign req_oid   = meta_reg[OID_LSB +: OPERATOR_ID_WIDTH];
   assign has_hdr   = meta_reg[HDR_BIT];
   assign has_bdy   = meta_reg[BDY_BIT];
   assign ready_sel = bus.out_tready[sel_reg];

   for (genvar gi = 0; gi < N_REGIONS; gi++) begin : g_region
      assign region_oid[gi] = stats_reg[gi*2*OPERATOR_ID_WIDTH +: OPERATOR_ID_WIDTH];
      assign region_cnt[gi] = stats_reg[gi*2*OPERATOR_ID_WIDTH + OPERATOR_ID_WIDTH +: OPERATOR_ID_WIDTH];
   end

   // Strict less-than while scanning upward keeps the lowest index on ties.
   always_comb begin
      match_found = 1'b0;
      match_idx   = '0;
      match_cnt   = '0;
      any_idx     = '0;
      any_cnt     = region_cnt[0];
      for (int r = 0; r < N_REGIONS; r++) begin
         if (region_oid[r] == req_oid && (!match_found || region_cnt[r] < match_cnt)) begin
            match_found = 1'b1;
            match_idx   = IDX_W'(r);
            match_cnt   = region_cnt[r];
         end
         if (region_cnt[r] < any_cnt) begin
            any_idx = IDX_W'(r);
            any_cnt = region_cnt[r];
         end
      end
   end

   always_comb begin
      state_next    = state_reg;
      sel_next      = sel_reg;
      pr_ctrl_next  = pr_ctrl_reg;
      pr_req_c      = 1'b0;
      load_meta     = 1'b0;
      cnt_inc       = 1'b0;
      meta_tready_c = 1'b0;
      hdr_tready_c  = 1'b0;
      bdy_tready_c  = 1'b0;
      valid_c       = 1'b0;
      tdata_c       = '0;
      tuser_c       = 2'd0;
      tlast_c       = 1'b0;
      case (state_reg)
         IDLE: begin
            meta_tready_c = 1'b1;
            if (bus.meta_tvalid) begin
               load_meta  = 1'b1;
               state_next = SELECT;
            end
         end
         SELECT: begin
            if (match_found) begin
               sel_next = match_idx;
            end else begin
               sel_next     = any_idx;
               pr_req_c     = 1'b1;
               pr_ctrl_next = {16'(any_idx), 16'(req_oid)};
            end
            state_next = SEND_META;
         end
         SEND_META: begin
            valid_c = 1'b1;
            tdata_c = HTTP_DATA_WIDTH'(meta_reg);
            tlast_c = ~has_hdr & ~has_bdy;
            if (ready_sel) begin
               if (has_hdr)      state_next = SEND_HDR;
               else if (has_bdy) state_next = SEND_BDY;
               else              state_next = DONE;
            end
         end
         SEND_HDR: begin
            valid_c      = bus.hdr_tvalid;
            hdr_tready_c = ready_sel;
            tdata_c      = bus.hdr_tdata;
            tuser_c      = 2'd1;
            tlast_c      = bus.hdr_tlast & ~has_bdy;
            if (bus.hdr_tvalid && ready_sel && bus.hdr_tlast)
               state_next = has_bdy ? SEND_BDY : DONE;
         end
         SEND_BDY: begin
            valid_c      = bus.bdy_tvalid;
            bdy_tready_c = ready_sel;
            tdata_c      = bus.bdy_tdata;
            tuser_c      = 2'd2;
            tlast_c      = bus.bdy_tlast;
            if (bus.bdy_tvalid && ready_sel && bus.bdy_tlast)
               state_next = DONE;
         end
         DONE: begin
            cnt_inc    = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_reg        <= IDLE;
         meta_reg         <= '0;
         sel_reg          <= '0;
         pr_ctrl_reg      <= '0;
         dispatch_cnt_reg <= '0;
         stats_reg        <= '0;
      end else begin
         state_reg   <= state_next;
         sel_reg     <= sel_next;
         pr_ctrl_reg <= pr_ctrl_next;
         stats_reg   <= bus.region_stats_in;
         if (load_meta)
            meta_reg <= bus.meta_tdata;
         if (cnt_inc)
            dispatch_cnt_reg <= dispatch_cnt_reg + 32'd1;
      end
   end

   // meta_tready is held low while reset is asserted so nothing is accepted mid-reset.
   assign bus.meta_tready  = meta_tready_c & ~areset;
   assign bus.hdr_tready   = hdr_tready_c;
   assign bus.bdy_tready   = bdy_tready_c;
   assign bus.out_tvalid   = valid_c ? (N_REGIONS'(1) << sel_reg) : '0;
   assign bus.out_tdata    = tdata_c;
   assign bus.out_tuser    = tuser_c;
   assign bus.out_tlast    = tlast_c;
   assign bus.pr_req       = pr_req_c;
   assign bus.pr_ctrl      = pr_ctrl_next;
   assign bus.dispatch_cnt = dispatch_cnt_reg;
endmodule

// File: doc/region_dispatcher.md
Name: region_dispatcher

Overview:
- Downstream of the HTTP load balancer, sitting between the HTTP module's meta/header/body streams and the N_REGIONS reconfigurable operator regions.
- Accepts one request at a time: meta word, then optional header beats, then optional body beats.
- Picks a target region from the live region statistics and forwards the whole request to it as one framed stream.
- When no region hosts the requested operator, issues a partial-reconfiguration request.

Parameters:
- HTTP_DATA_WIDTH, 512, width of header/body/output data beats
- HTTP_META_WIDTH, 98, meta word width: {oid[97:82], has_body[81], has_headers[80], method[79:48], meta_meta[47:0]}
- HTTP_META_META_WIDTH, 48, width of meta_meta field
- HTTP_METHOD_WIDTH, 32, width of method field
- OPERATOR_ID_WIDTH, 16, operator id / active-count width
- N_REGIONS, 4, number of regions (2..16)

Ports:
- aclk  in  1  clock
- areset  in  1  synchronous, active-high reset
- meta_tvalid/meta_tready  in/out  1/1  meta stream handshake
- meta_tdata  in  HTTP_META_WIDTH  request meta
- hdr_tvalid/hdr_tready/hdr_tlast  in/out/in  1/1/1  header stream
- hdr_tdata  in  HTTP_DATA_WIDTH  header beat
- bdy_tvalid/bdy_tready/bdy_tlast  in/out/in  1/1/1  body stream
- bdy_tdata  in  HTTP_DATA_WIDTH  body beat
- region_stats_in  in  N_REGIONS*2*OPERATOR_ID_WIDTH  per region r: bits [r*32 +: 16] loaded oid, [r*32+16 +: 16] active count
- out_tvalid  out  N_REGIONS  one-hot valid to the selected region
- out_tready  in  N_REGIONS  per-region ready
- out_tdata  out  HTTP_DATA_WIDTH  shared data bus
- out_tuser  out  2  beat type: 0 meta, 1 header, 2 body
- out_tlast  out  1  last beat of request
- pr_req  out  1  one-cycle reconfiguration request pulse
- pr_ctrl  out  32  {region index[31:16], oid[15:0]}; held until the next pr_req
- dispatch_cnt  out  32  requests completed; wraps at 2^32

Behaviour:
- Reset values: all outputs 0; state IDLE. Reset mid-request returns the block to IDLE the next cycle and abandons the partial request. The upstream and region sides resynchronise themselves.
- region_stats_in is registered every cycle. Selection uses the registered copy.
- IDLE:
  - meta_tready=1.
  - On meta handshake, latch meta_tdata; go to SELECT.
- SELECT (1 cycle, meta_tready=0):
  - Candidates are regions whose loaded oid equals the request oid. Choose the lowest active count; ties go to the lowest index.
  - If there is no candidate, choose the lowest active count over all regions (ties lowest index). Pulse pr_req=1 this cycle and load pr_ctrl={index, oid}.
  - Latch the selected index sel. Go to SEND_META.
- SEND_META:
  - out_tvalid[sel]=1, out_tdata = meta zero-extended, out_tuser=0.
  - out_tlast = ~has_headers & ~has_body.
  - On out_tready[sel], go to SEND_HDR if has_headers, else SEND_BDY if has_body, else DONE.
- SEND_HDR:
  - Combinational pass-through: out_tvalid[sel]=hdr_tvalid, hdr_tready=out_tready[sel], out_tdata=hdr_tdata, out_tuser=1.
  - out_tlast = hdr_tlast & ~has_body.
  - On a handshake with hdr_tlast, go to SEND_BDY if has_body, else DONE.
- SEND_BDY:
  - Same pass-through from the body stream, out_tuser=2, out_tlast=bdy_tlast.
  - On a handshake with bdy_tlast, go to DONE.
- DONE (1 cycle): dispatch_cnt+1; go to IDLE.
- Throughput and latency:
  - Minimum meta-accept to out-meta-valid latency: 2 cycles.
  - Minimum meta-only request: 4 cycles.
- General rules:
  - Non-selected out_tvalid bits are always 0.
  - hdr_tready=0 outside SEND_HDR; bdy_tready=0 outside SEND_BDY.
  - Under back-pressure, the out signals hold stable while valid && !ready.
  - The header/body streams are never consumed for a request whose flag is 0.
  - A stats change during a request does not alter sel.

Test Plan:
- Stats r0={oid 5,cnt 3}, r1={5,1}, r2={7,0}, r3={5,1}; meta oid=5, hdr=0, bdy=0 -> out_tvalid=4'b0010, tuser=0, tlast=1, pr_req stays 0, dispatch_cnt=1.
- Meta oid=9 (no match), counts {4,2,2,6} -> sel=1, pr_req pulses once with pr_ctrl=0x00010009, then meta beat forwarded to r1.
- has_headers=1, has_body=1; 3 header beats then 2 body beats, out_tready always 1 -> 6 output beats, tuser sequence 0,1,1,1,2,2, tlast only on the final body beat.
- Same request with out_tready[sel] toggling every other cycle -> no beat lost or duplicated, data stable while stalled, hdr_tready mirrors out_tready.
- has_headers=0, has_body=1 with hdr_tvalid held high -> hdr_tready never asserts; body beats forwarded with tuser=2.
- areset asserted mid-SEND_BDY -> next cycle all out_tvalid=0, meta_tready=0, dispatch_cnt=0, pr_ctrl=0; after release, meta_tready=1 and a new request dispatches normally.
